// File: rtl/arrayadd_pkg.sv
// arrayadd_pkg: shared defaults, FSM states and memory init paths for the array-add datapath
package arrayadd_pkg;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DEPTH = 256;
    localparam string RESULT_MEM_INIT = "result_mem.hex";
    localparam string OPERAND_MEM_INIT = "operand_mem.hex";
    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;
endpackage

// File: rtl/result_mem.sv
// result_mem: 1-write/1-read synchronous RAM, read-first, registered read port
module result_mem #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int DEPTH = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_data;
    // write port; storage is never reset so it can map to block RAM
    always_ff @(posedge clk) begin
        if (we) r_mem[wr_addr] <= wr_data;
    end
    // read port samples the array before this edge's write lands (read-first)
    always_ff @(posedge clk) begin
        if (!rst_n) r_rd_data <= '0;
        else r_rd_data <= r_mem[rd_addr];
    end
    assign rd_data = r_rd_data;
endmodule

// File: rtl/result_writer.sv
// result_writer: stores a valid/ready stream of result words into memory with running checksum
module result_writer
    import arrayadd_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [ADDR_W-1:0] wr_index,
    output logic [ADDR_W:0]   count,
    output logic              done,
    output logic [DATA_W-1:0] checksum,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);
    state_t            r_state, w_next;
    logic [ADDR_W-1:0] r_wr_index;
    logic [ADDR_W:0]   r_count;
    logic [DATA_W-1:0] r_checksum;
    logic              r_done;
    logic              w_beat, w_last;
    logic [ADDR_W-1:0] w_index_next;

    // a beat coinciding with start is discarded so the restart begins clean
    assign w_beat = in_valid && in_ready && !start;
    assign w_last = r_wr_index == ADDR_W'(DEPTH - 1);
    // after the last entry the index returns to 0; this is also the natural wrap when DEPTH fills the address space
    assign w_index_next = w_last ? '0 : r_wr_index + 1'b1;

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else r_state <= w_next;
    end

    // next state and ready, decoded from state only so in_valid never reaches in_ready
    always_comb begin
        w_next = r_state;
        in_ready = r_state == WRITE;
        if (start) w_next = WRITE;
        else if (w_beat && w_last) w_next = DONE;
    end

    // index, count, checksum and completion flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_index <= '0;
            r_count <= '0;
            r_checksum <= '0;
            r_done <= 1'b0;
        end else if (start) begin
            r_wr_index <= '0;
            r_count <= '0;
            r_checksum <= '0;
            r_done <= 1'b0;
        end else if (w_beat) begin
            r_wr_index <= w_index_next;
            r_count <= r_count + 1'b1;
            r_checksum <= r_checksum + in_data;
            r_done <= w_last;
        end
    end

    result_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_mem (
        .clk(clk),
        .rst_n(rst_n),
        .we(w_beat),
        .wr_addr(r_wr_index),
        .wr_data(in_data),
        .rd_addr(rd_addr),
        .rd_data(rd_data)
    );

    assign wr_index = r_wr_index;
    assign count = r_count;
    assign done = r_done;
    assign checksum = r_checksum;
endmodule
